// File: rtl/encrypt_row_fetch.sv
// encrypt_row_fetch: walks the BIG_N public-key rows in SRAM and streams each row to encrypt.
// Optional feature macro SKIP_UNSELECTED_EN: rows whose LFSR select bit is 0 are neither fetched nor emitted.
module encrypt_row_fetch #(
    parameter int          PLAINTEXT_WIDTH  = 6,
    parameter int          CIPHERTEXT_WIDTH = 10,
    parameter int          DIMENSION        = 10,
    parameter int          BIG_N            = 30,
    parameter int          ADDR_WIDTH       = 8,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    localparam int         ROW_WIDTH        = (DIMENSION + 1) * CIPHERTEXT_WIDTH,
    localparam int         IDX_WIDTH        = $clog2(BIG_N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PLAINTEXT_WIDTH-1:0] plaintext,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       sram_en,
    output logic [ADDR_WIDTH-1:0]      sram_addr,
    input  logic [ROW_WIDTH-1:0]       sram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROW_WIDTH-1:0]       publickey_row,
    output logic [IDX_WIDTH-1:0]       row,
    output logic                       noise_select,
    output logic [PLAINTEXT_WIDTH-1:0] plaintext_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_REQ,
        S_CAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [15:0]           r_lfsr;
    logic [IDX_WIDTH-1:0]  r_row_q;
    logic                  r_sel_q;
    logic [ADDR_WIDTH-1:0] r_base_q;

    logic [15:0]           w_lfsr_next;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_row_addr;

    // Galois right-shift LFSR; the row address wraps modulo 2^ADDR_WIDTH.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_last      = (r_row_q == IDX_WIDTH'(BIG_N - 1));
    assign w_row_addr  = r_base_q + ADDR_WIDTH'(r_row_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_row_q       <= '0;
            r_sel_q       <= 1'b0;
            r_base_q      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sram_en       <= 1'b0;
            sram_addr     <= '0;
            out_valid     <= 1'b0;
            publickey_row <= '0;
            row           <= '0;
            noise_select  <= 1'b0;
            plaintext_out <= '0;
        end else begin
            done    <= 1'b0;
            sram_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        plaintext_out <= plaintext;
                        r_base_q      <= base_addr;
                        r_row_q       <= '0;
                        busy          <= 1'b1;
                        r_state       <= S_SEL;
                    end
                end
                S_SEL: begin
                    r_sel_q <= r_lfsr[0];
                    r_lfsr  <= w_lfsr_next;
`ifdef SKIP_UNSELECTED_EN
                    if (!r_lfsr[0]) begin
                        if (w_last) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row_q <= r_row_q + IDX_WIDTH'(1);
                        end
                    end else begin
                        sram_en   <= 1'b1;
                        sram_addr <= w_row_addr;
                        r_state   <= S_REQ;
                    end
`else
                    sram_en   <= 1'b1;
                    sram_addr <= w_row_addr;
                    r_state   <= S_REQ;
`endif
                end
                S_REQ: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    publickey_row <= sram_rdata;
                    row           <= r_row_q;
                    noise_select  <= r_sel_q;
                    out_valid     <= 1'b1;
                    r_state       <= S_OUT;
                end
                // Beat outputs are only rewritten in CAP, so they hold steady under backpressure.
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (w_last) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row_q <= r_row_q + IDX_WIDTH'(1);
                            r_state <= S_SEL;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_row_fetch.sv
// Randomized self-checking bench for encrypt_row_fetch against a row-list reference model.
// Build with +define+SKIP_UNSELECTED_EN to exercise the row-skipping variant.
module tb_encrypt_row_fetch;

    localparam int BIG_N      = 30;
    localparam int ROW_W      = 110;
    localparam int AW         = 8;
    localparam int PW         = 6;
    localparam int IW         = 5;
    localparam int PASS_LIMIT = 4 * BIG_N + 200;
`ifdef SKIP_UNSELECTED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [PW-1:0]    plaintext = '0;
    logic [AW-1:0]    base_addr = '0;
    logic             out_ready = 1'b1;
    logic [ROW_W-1:0] sram_rdata = '0;
    logic             busy, done, sram_en, out_valid, noise_select;
    logic [AW-1:0]    sram_addr;
    logic [ROW_W-1:0] publickey_row;
    logic [IW-1:0]    row;
    logic [PW-1:0]    plaintext_out;

    typedef struct packed {
        logic [IW-1:0]    r;
        logic [ROW_W-1:0] d;
        logic             s;
        logic [PW-1:0]    p;
    } beat_t;

    logic [ROW_W-1:0] mem [0:(1<<AW)-1];
    beat_t            gotBeats[$];
    beat_t            expBeats[$];
    logic [AW-1:0]    gotAddrs[$];
    logic [AW-1:0]    expAddrs[$];
    logic [15:0]      modelLfsr;
    int               expSpan;
    int               vectors = 0;
    int               miscompares = 0;

    encrypt_row_fetch dut (
        .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .base_addr(base_addr),
        .busy(busy), .done(done), .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .publickey_row(publickey_row), .row(row),
        .noise_select(noise_select), .plaintext_out(plaintext_out)
    );

    always #5 clk = ~clk;

    // SRAM: one-cycle read latency, random junk on cycles without a read.
    always @(posedge clk) begin
        if (sram_en) sram_rdata <= mem[sram_addr];
        else         sram_rdata <= ROW_W'({$urandom, $urandom, $urandom, $urandom});
    end

    // Reference: each row draws one LFSR bit; selected (or all, without skip) rows become beats.
    task automatic modelPass(input logic [AW-1:0] base, input logic [PW-1:0] pt);
        logic          s;
        logic [AW-1:0] a;
        int            k;
        k = 0;
        expBeats.delete();
        expAddrs.delete();
        for (int r = 0; r < BIG_N; r++) begin
            s = modelLfsr[0];
            modelLfsr = (modelLfsr >> 1) ^ (s ? 16'hB400 : 16'h0000);
            if (SKIP && !s) continue;
            a = AW'((int'(base) + r) % (1 << AW));
            expAddrs.push_back(a);
            expBeats.push_back({IW'(r), mem[a], s, pt});
            k++;
        end
        expSpan = 2 + 4 * k + (BIG_N - k);
    endtask

    // Runs one pass; span counts cycles from the start cycle through the done cycle inclusive.
    task automatic doPass(input logic [AW-1:0] base, input logic [PW-1:0] pt, input int stallRow,
                          input int stallLen, output int span, output int stalls,
                          output int heldBad, output int stallReads);
        beat_t cur, prev;
        bit    stalled, prevStalled;
        int    left;
        gotBeats.delete();
        gotAddrs.delete();
        span = -1; stalls = 0; heldBad = 0; stallReads = 0;
        left = stallLen; prevStalled = 1'b0; prev = '0;
        @(posedge clk); #1;
        start = 1'b1; plaintext = pt; base_addr = base; out_ready = 1'b1;
        for (int c = 0; c < PASS_LIMIT; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (out_valid && int'(row) == stallRow && left > 0) begin
                    out_ready = 1'b0;
                    left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
            @(negedge clk);
            cur = {row, publickey_row, noise_select, plaintext_out};
            if (sram_en) gotAddrs.push_back(sram_addr);
            if (out_valid && out_ready) gotBeats.push_back(cur);
            stalled = out_valid && !out_ready;
            if (stalled) begin
                stalls++;
                if (sram_en) stallReads++;
                if (prevStalled && cur !== prev) heldBad++;
            end
            prevStalled = stalled;
            prev = cur;
            if (done) begin
                span = c + 1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        int reads, busyHigh;
        reads = 0; busyHigh = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (busy !== 1'b0)          begin miscompares++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)          begin miscompares++; $display("[TB] FAIL reset done: got %b want 0", done); end
        vectors++; if (sram_en !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset sram_en: got %b want 0", sram_en); end
        vectors++; if (sram_addr !== '0)       begin miscompares++; $display("[TB] FAIL reset sram_addr: got %h want 0", sram_addr); end
        vectors++; if (out_valid !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
        vectors++; if (publickey_row !== '0)   begin miscompares++; $display("[TB] FAIL reset publickey_row: got %h want 0", publickey_row); end
        vectors++; if (row !== '0)             begin miscompares++; $display("[TB] FAIL reset row: got %0d want 0", row); end
        vectors++; if (noise_select !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset noise_select: got %b want 0", noise_select); end
        vectors++; if (plaintext_out !== '0)   begin miscompares++; $display("[TB] FAIL reset plaintext_out: got %h want 0", plaintext_out); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_en) reads++;
            if (busy !== 1'b0) busyHigh++;
        end
        vectors++; if (reads !== 0)    begin miscompares++; $display("[TB] FAIL idle reads: got %0d want 0", reads); end
        vectors++; if (busyHigh !== 0) begin miscompares++; $display("[TB] FAIL idle busy cycles: got %0d want 0", busyHigh); end
    endtask

    task automatic test_full_pass;
        int span, stalls, heldBad, stallReads;
        logic [PW-1:0] pt;
        pt = PW'($urandom);
        modelPass(8'h10, pt);
        doPass(8'h10, pt, -1, 0, span, stalls, heldBad, stallReads);
        vectors++; if (span !== expSpan) begin miscompares++; $display("[TB] FAIL full span: got %0d want %0d", span, expSpan); end
        vectors++; if (gotBeats.size() !== expBeats.size()) begin miscompares++; $display("[TB] FAIL full beats: got %0d want %0d", gotBeats.size(), expBeats.size()); end
        vectors++; if (gotAddrs.size() !== expAddrs.size()) begin miscompares++; $display("[TB] FAIL full reads: got %0d want %0d", gotAddrs.size(), expAddrs.size()); end
        for (int i = 0; i < expBeats.size() && i < gotBeats.size(); i++) begin
            vectors++; if (gotBeats[i] !== expBeats[i]) begin miscompares++; $display("[TB] FAIL full beat %0d: got %h want %h", i, gotBeats[i], expBeats[i]); end
        end
        for (int i = 0; i < expAddrs.size() && i < gotAddrs.size(); i++) begin
            vectors++; if (gotAddrs[i] !== expAddrs[i]) begin miscompares++; $display("[TB] FAIL full addr %0d: got %h want %h", i, gotAddrs[i], expAddrs[i]); end
        end
`ifdef SKIP_UNSELECTED_EN
        if (gotBeats.size() >= 2) begin
            vectors++; if ({gotBeats[0].r, gotBeats[0].s, gotBeats[1].r, gotBeats[1].s} !== {5'd0, 1'b1, 5'd5, 1'b1}) begin
                miscompares++; $display("[TB] FAIL skip first beats: got r%0d/%b r%0d/%b want r0/1 r5/1", gotBeats[0].r, gotBeats[0].s, gotBeats[1].r, gotBeats[1].s);
            end
        end
        vectors++; if (gotAddrs.size() < 2 || gotAddrs[1] !== 8'h15) begin miscompares++; $display("[TB] FAIL skip second read: got %0d reads want second at 15", gotAddrs.size()); end
`else
        if (gotBeats.size() >= 6) begin
            vectors++; if ({gotBeats[0].s, gotBeats[1].s, gotBeats[2].s, gotBeats[3].s, gotBeats[4].s, gotBeats[5].s} !== 6'b100001) begin
                miscompares++; $display("[TB] FAIL select bits rows 0..5: got %b%b%b%b%b%b want 100001", gotBeats[0].s, gotBeats[1].s, gotBeats[2].s, gotBeats[3].s, gotBeats[4].s, gotBeats[5].s);
            end
        end
        vectors++; if (span !== 122) begin miscompares++; $display("[TB] FAIL full pass length: got %0d want 122", span); end
`endif
    endtask

    task automatic test_addr_wrap;
        int span, stalls, heldBad, stallReads;
        logic [PW-1:0] pt;
        pt = PW'($urandom);
        modelPass(8'hF0, pt);
        doPass(8'hF0, pt, -1, 0, span, stalls, heldBad, stallReads);
        vectors++; if (span !== expSpan) begin miscompares++; $display("[TB] FAIL wrap span: got %0d want %0d", span, expSpan); end
        vectors++; if (gotBeats.size() !== expBeats.size()) begin miscompares++; $display("[TB] FAIL wrap beats: got %0d want %0d", gotBeats.size(), expBeats.size()); end
        for (int i = 0; i < expBeats.size() && i < gotBeats.size(); i++) begin
            vectors++; if (gotBeats[i] !== expBeats[i]) begin miscompares++; $display("[TB] FAIL wrap beat %0d: got %h want %h", i, gotBeats[i], expBeats[i]); end
        end
        for (int i = 0; i < expAddrs.size() && i < gotAddrs.size(); i++) begin
            vectors++; if (gotAddrs[i] !== expAddrs[i]) begin miscompares++; $display("[TB] FAIL wrap addr %0d: got %h want %h", i, gotAddrs[i], expAddrs[i]); end
        end
`ifndef SKIP_UNSELECTED_EN
        vectors++; if (gotAddrs.size() != BIG_N || gotAddrs[16] !== 8'h00 || gotAddrs[29] !== 8'h0D) begin
            miscompares++; $display("[TB] FAIL wrap endpoints: got %0d reads want row16=00 row29=0D", gotAddrs.size());
        end
`endif
    endtask

    task automatic test_backpressure;
        int span, stalls, heldBad, stallReads, wantStalls;
        logic [AW-1:0] base;
        logic [PW-1:0] pt;
        base = AW'($urandom); pt = PW'($urandom);
        modelPass(base, pt);
        wantStalls = 0;
        foreach (expBeats[i]) if (expBeats[i].r == IW'(3)) wantStalls = 7;
        doPass(base, pt, 3, 7, span, stalls, heldBad, stallReads);
        vectors++; if (stalls !== wantStalls) begin miscompares++; $display("[TB] FAIL stall cycles: got %0d want %0d", stalls, wantStalls); end
        vectors++; if (heldBad !== 0) begin miscompares++; $display("[TB] FAIL beat changed during stall: got %0d changes want 0", heldBad); end
        vectors++; if (stallReads !== 0) begin miscompares++; $display("[TB] FAIL reads during stall: got %0d want 0", stallReads); end
        vectors++; if (span !== expSpan + wantStalls) begin miscompares++; $display("[TB] FAIL stall span: got %0d want %0d", span, expSpan + wantStalls); end
        vectors++; if (gotBeats.size() !== expBeats.size()) begin miscompares++; $display("[TB] FAIL stall beats: got %0d want %0d", gotBeats.size(), expBeats.size()); end
        for (int i = 0; i < expBeats.size() && i < gotBeats.size(); i++) begin
            vectors++; if (gotBeats[i] !== expBeats[i]) begin miscompares++; $display("[TB] FAIL stall beat %0d: got %h want %h", i, gotBeats[i], expBeats[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int span, stalls, heldBad, stallReads;
        logic [AW-1:0] base;
        logic [PW-1:0] pt;
        for (int p = 0; p < 2; p++) begin
            base = AW'($urandom); pt = PW'($urandom);
            modelPass(base, pt);
            doPass(base, pt, -1, 0, span, stalls, heldBad, stallReads);
            vectors++; if (span !== expSpan) begin miscompares++; $display("[TB] FAIL b2b%0d span: got %0d want %0d", p, span, expSpan); end
            vectors++; if (gotBeats.size() !== expBeats.size()) begin miscompares++; $display("[TB] FAIL b2b%0d beats: got %0d want %0d", p, gotBeats.size(), expBeats.size()); end
            for (int i = 0; i < expBeats.size() && i < gotBeats.size(); i++) begin
                vectors++; if (gotBeats[i] !== expBeats[i]) begin miscompares++; $display("[TB] FAIL b2b%0d beat %0d: got %h want %h", p, i, gotBeats[i], expBeats[i]); end
            end
        end
    endtask

    task automatic test_reset_midpass;
        int span, stalls, heldBad, stallReads, doneSeen;
        bit hit;
        logic [AW-1:0] base;
        logic [PW-1:0] pt;
        hit = 1'b0; doneSeen = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'($urandom); plaintext = PW'($urandom); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < PASS_LIMIT; i++) begin
            @(negedge clk);
            if (out_valid && row >= IW'(10)) begin
                hit = 1'b1;
                break;
            end
        end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("[TB] FAIL midpass reached row 10: got %b want 1", hit); end
        #1 rst = 1'b1;
        #1;
        vectors++; if ({busy, done, sram_en, out_valid, noise_select} !== 5'b0) begin miscompares++; $display("[TB] FAIL midpass reset flags: got %b want 00000", {busy, done, sram_en, out_valid, noise_select}); end
        vectors++; if ({publickey_row, row, plaintext_out, sram_addr} !== '0) begin miscompares++; $display("[TB] FAIL midpass reset data: got %h/%0d/%h/%h want zeros", publickey_row, row, plaintext_out, sram_addr); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        vectors++; if (doneSeen !== 0) begin miscompares++; $display("[TB] FAIL done after reset: got %0d pulses want 0", doneSeen); end
        modelLfsr = 16'hACE1;
        base = AW'($urandom); pt = PW'($urandom);
        modelPass(base, pt);
        doPass(base, pt, -1, 0, span, stalls, heldBad, stallReads);
        vectors++; if (gotBeats.size() == 0 || gotBeats[0].r !== IW'(0)) begin miscompares++; $display("[TB] FAIL restart first row: got %0d beats want first row 0", gotBeats.size()); end
        vectors++; if (span !== expSpan) begin miscompares++; $display("[TB] FAIL restart span: got %0d want %0d", span, expSpan); end
        vectors++; if (gotBeats.size() !== expBeats.size()) begin miscompares++; $display("[TB] FAIL restart beats: got %0d want %0d", gotBeats.size(), expBeats.size()); end
        for (int i = 0; i < expBeats.size() && i < gotBeats.size(); i++) begin
            vectors++; if (gotBeats[i] !== expBeats[i]) begin miscompares++; $display("[TB] FAIL restart beat %0d: got %h want %h", i, gotBeats[i], expBeats[i]); end
        end
    endtask

    initial begin
        logic [127:0] w;
        for (int i = 0; i < (1 << AW); i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            mem[i] = w[ROW_W-1:0];
        end
        modelLfsr = 16'hACE1;
        test_reset();
        test_full_pass();
        test_addr_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
